lpm_sequencer: RTL and testbench
================================

Name: lpm_sequencer

Overview:
- Multi-cycle sequencer for the AVR LPM family: LPM (implied R0), LPM Rd,Z and LPM Rd,Z+.
- Sits beside the instruction decoder. On a start pulse it takes the program-memory address port from instruction fetch and reads the word at Z>>1.
- Selects the byte by Z[0], writes it to the register file and optionally post-increments Z.
- Completes in 3 clocks, matching ATmega32A LPM timing.

Parameters:
PM_ADDR_W, 14, program-memory word-address width (16K words = 32 KB)
Z_W, 16, Z pointer width

Ports:
clk  input  1  system clock, all state on rising edge
reset_n  input  1  reset, synchronous, active-low
start  input  1  one-cycle pulse from decoder: LPM instruction issued
mode  input  2  00 = LPM (dest R0), 01 = LPM Rd,Z, 10 = LPM Rd,Z+, 11 = reserved
rd_in  input  5  destination register (ignored for mode 00)
z_in  input  Z_W  current Z (R31:R30) value
pm_data  input  16  program-memory read data, valid the cycle after pm_addr is presented
busy  output  1  sequencer not idle
stall_fetch  output  1  holds PC and fetch
pm_sel  output  1  1 = program-memory address mux selects pm_addr instead of PC
pm_addr  output  PM_ADDR_W  LPM word address
rf_we  output  1  register-file write enable
rf_waddr  output  5  register-file write address
rf_wdata  output  8  register-file write data
z_we  output  1  Z pointer write enable
z_wdata  output  Z_W  new Z value
done  output  1  one-cycle completion pulse

Behaviour:
- Reset (reset_n low at a rising edge): state = IDLE; all outputs 0; latched fields cleared. Reset overrides start and any in-flight operation. No rf or Z write occurs for an aborted operation.

States:
- IDLE
  - busy = 0, all outputs 0.
  - start = 1 with mode != 11: latch mode, Z, and destination (rd_in, or 0 when mode = 00), then go to ADDR.
  - start with mode = 11: ignored, stay in IDLE.
- ADDR (cycle 1 after start is sampled)
  - busy = 1, stall_fetch = 1, pm_sel = 1.
  - pm_addr = Z_latched[PM_ADDR_W:1].
  - Go to READ.
- READ (cycle 2)
  - busy = 1, stall_fetch = 1, pm_sel = 1, pm_addr held.
  - Capture the byte from pm_data: Z_latched[0] = 0 takes bits 7:0, Z_latched[0] = 1 takes bits 15:8.
  - Go to WB.
- WB (cycle 3)
  - busy = 1, stall_fetch = 0, pm_sel = 0, so fetch of the next instruction proceeds this cycle.
  - rf_we = 1, rf_waddr = latched destination, rf_wdata = captured byte, done = 1.
  - If mode = 10: z_we = 1, z_wdata = Z_latched + 1, modulo 2^Z_W (0xFFFF wraps to 0x0000).
  - Go to IDLE.

Boundary conditions:
- Z[15] beyond PM_ADDR_W: the upper bits are dropped and the address wraps within program memory.
- mode = 10 with destination R30 or R31: z_we is suppressed. Only the loaded byte is written, which defines the AVR-undefined case.
- start asserted while busy: ignored. No queueing, latched fields unchanged.
- start in the same cycle as WB: ignored. The decoder must not issue start until busy = 0.
- Latency: start sampled at edge 0; rf and Z writes take effect at edge 3. Back-to-back LPMs are possible every 4 cycles minimum (IDLE cycle between).
- Outputs are registered or decoded from state only; there is no combinational path from start to outputs.

Test Plan:
- Mode 00, Z = 0x0101, PM[0x0080] = 0xABCD.
  - Cycles 1–2: pm_sel = 1, pm_addr = 0x0080.
  - Cycle 3: rf_we = 1, rf_waddr = 0, rf_wdata = 0xAB, z_we = 0, done = 1.
- Mode 10, rd = 5, Z = 0x0200, PM[0x0100] = 0x1234 -> cycle 3: rf_waddr = 5, rf_wdata = 0x34, z_we = 1, z_wdata = 0x0201.
- Mode 10, rd = 2, Z = 0xFFFF, PM[0x3FFF] = 0x5A00 -> pm_addr = 0x3FFF, rf_wdata = 0x5A, z_wdata = 0x0000.
- Mode 10, rd = 31, Z = 0x0010 -> rf_we = 1 at R31, z_we = 0.
- Second start pulse in ADDR and again in WB -> ignored: exactly one done pulse, latched Z unchanged, busy = 0 the cycle after WB.
- reset_n low during READ -> next cycle all outputs 0, state IDLE, no rf_we or z_we. A following start runs a full 3-cycle sequence normally.

Source files
------------

// File: rtl/lpm_sequencer.sv
// rtl/lpm_sequencer.sv - three-cycle LPM sequencer: program-memory byte load into the register file, optional Z post-increment
module lpm_sequencer #(
  parameter int PM_ADDR_W = 14,
  parameter int Z_W       = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [1:0]           mode,
  input  logic [4:0]           rd_in,
  input  logic [Z_W-1:0]       z_in,
  input  logic [15:0]          pm_data,
  output logic                 busy,
  output logic                 stall_fetch,
  output logic                 pm_sel,
  output logic [PM_ADDR_W-1:0] pm_addr,
  output logic                 rf_we,
  output logic [4:0]           rf_waddr,
  output logic [7:0]           rf_wdata,
  output logic                 z_we,
  output logic [Z_W-1:0]       z_wdata,
  output logic                 done
);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_READ, S_WB} state_t;

  state_t         state_q, state_d;
  logic [1:0]     mode_q, mode_d;
  logic [Z_W-1:0] z_q, z_d;
  logic [4:0]     rd_q, rd_d;
  logic [7:0]     byte_q, byte_d;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      mode_q  <= 2'b00;
      z_q     <= '0;
      rd_q    <= 5'd0;
      byte_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      z_q     <= z_d;
      rd_q    <= rd_d;
      byte_q  <= byte_d;
    end
  end

  // Outputs depend only on state and latched fields, never on start.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    z_d         = z_q;
    rd_d        = rd_q;
    byte_d      = byte_q;
    busy        = 1'b0;
    stall_fetch = 1'b0;
    pm_sel      = 1'b0;
    pm_addr     = '0;
    rf_we       = 1'b0;
    rf_waddr    = 5'd0;
    rf_wdata    = 8'h00;
    z_we        = 1'b0;
    z_wdata     = '0;
    done        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start && mode != 2'b11) begin
          mode_d  = mode;
          z_d     = z_in;
          rd_d    = (mode == 2'b00) ? 5'd0 : rd_in;
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        busy        = 1'b1;
        stall_fetch = 1'b1;
        pm_sel      = 1'b1;
        pm_addr     = z_q[PM_ADDR_W:1];
        state_d     = S_READ;
      end
      S_READ: begin
        busy        = 1'b1;
        stall_fetch = 1'b1;
        pm_sel      = 1'b1;
        pm_addr     = z_q[PM_ADDR_W:1];
        byte_d      = z_q[0] ? pm_data[15:8] : pm_data[7:0];
        state_d     = S_WB;
      end
      S_WB: begin
        busy     = 1'b1;
        rf_we    = 1'b1;
        rf_waddr = rd_q;
        rf_wdata = byte_q;
        done     = 1'b1;
        // Post-increment loses to the loaded byte when the destination is R30/R31.
        if (mode_q == 2'b10 && rd_q[4:1] != 4'b1111) begin
          z_we    = 1'b1;
          z_wdata = z_q + {{(Z_W-1){1'b0}}, 1'b1};
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_lpm_sequencer.sv
// tb/tb_lpm_sequencer.sv - scoreboard bench for lpm_sequencer
module tb_lpm_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [4:0]  rd_in = 5'd0;
  logic [15:0] z_in = 16'h0000;
  logic [15:0] pm_data = 16'h0000;
  logic        busy, stall_fetch, pm_sel, rf_we, z_we, done;
  logic [13:0] pm_addr;
  logic [4:0]  rf_waddr;
  logic [7:0]  rf_wdata;
  logic [15:0] z_wdata;

  lpm_sequencer #(.PM_ADDR_W(14), .Z_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .mode(mode), .rd_in(rd_in),
    .z_in(z_in), .pm_data(pm_data), .busy(busy), .stall_fetch(stall_fetch),
    .pm_sel(pm_sel), .pm_addr(pm_addr), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .z_we(z_we), .z_wdata(z_wdata), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  waddr;
    logic [7:0]  wdata;
    logic        zwe;
    logic [15:0] zwdata;
  } exp_t;

  exp_t        sb_q[$];
  logic [15:0] pm_mem [int];
  int          n_checks = 0;
  int          n_pass = 0;
  int          n_pushed = 0;
  int          n_done = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [15:0] word_at(input logic [13:0] a);
    if (pm_mem.exists(int'(a))) return pm_mem[int'(a)];
    return {2'b11, a} ^ 16'h5A3C;
  endfunction

  // Synchronous program memory: data valid the cycle after the address.
  always @(posedge clk) pm_data <= word_at(pm_addr);

  always @(negedge clk) begin
    if (reset_n && (done || rf_we || z_we)) begin
      n_done += done ? 1 : 0;
      if (sb_q.size() == 0) begin
        check("unexpected_write", {29'd0, done, rf_we, z_we}, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("done", done, 1'b1);
        check("rf_we", rf_we, 1'b1);
        check("rf_waddr", rf_waddr, e.waddr);
        check("rf_wdata", rf_wdata, e.wdata);
        check("z_we", z_we, e.zwe);
        check("z_wdata", z_wdata, e.zwdata);
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_outs"}, {busy, stall_fetch, pm_sel, rf_we, z_we, done}, 6'd0);
    check({tag, "_data"}, {pm_addr, rf_waddr, rf_wdata, z_wdata}, 43'd0);
  endtask

  // Called at a falling edge; returns at the falling edge of the IDLE cycle after WB.
  task automatic issue(input logic [1:0] m, input logic [4:0] rd, input logic [15:0] z,
                       input bit abort, input bit extra);
    logic [13:0] wa;
    logic [15:0] w;
    exp_t e;
    wa = 14'((z >> 1) & 16'h3FFF);
    w  = word_at(wa);
    e.waddr  = (m == 2'b00) ? 5'd0 : rd;
    e.wdata  = z[0] ? w[15:8] : w[7:0];
    e.zwe    = (m == 2'b10) && (e.waddr < 5'd30);
    e.zwdata = e.zwe ? z + 16'd1 : 16'd0;
    start = 1'b1; mode = m; rd_in = rd; z_in = z;
    if (!abort) begin
      sb_q.push_back(e);
      n_pushed++;
    end
    @(negedge clk);
    check("addr_ctl", {busy, stall_fetch, pm_sel}, 3'b111);
    check("addr_pm", pm_addr, wa);
    if (extra) begin
      mode = 2'b01; rd_in = 5'd9; z_in = 16'h7777;
    end else start = 1'b0;
    @(negedge clk);
    start = 1'b0;
    check("read_ctl", {busy, stall_fetch, pm_sel}, 3'b111);
    check("read_pm", pm_addr, wa);
    if (abort) begin
      reset_n = 1'b0;
      @(negedge clk);
      check_all_zero("abort");
      reset_n = 1'b1;
      return;
    end
    if (extra) begin
      start = 1'b1; mode = 2'b10; z_in = 16'h1111;
    end
    @(negedge clk);
    check("wb_ctl", {busy, stall_fetch, pm_sel}, 3'b100);
    @(negedge clk);
    start = 1'b0;
    check("idle_busy", busy, 1'b0);
    if (extra) begin
      @(negedge clk);
      check("extra_ignored", busy, 1'b0);
    end
  endtask

  initial begin
    pm_mem[32'h0080] = 16'hABCD;
    pm_mem[32'h0100] = 16'h1234;
    pm_mem[32'h3FFF] = 16'h5A00;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    reset_n = 1'b1;
    @(negedge clk);
    check_all_zero("idle");

    issue(2'b00, 5'd7,  16'h0101, 1'b0, 1'b0);
    issue(2'b10, 5'd5,  16'h0200, 1'b0, 1'b0);
    issue(2'b10, 5'd2,  16'hFFFF, 1'b0, 1'b0);
    issue(2'b10, 5'd31, 16'h0010, 1'b0, 1'b0);
    issue(2'b10, 5'd30, 16'h0011, 1'b0, 1'b0);
    issue(2'b01, 5'd12, 16'hC0DF, 1'b0, 1'b0);
    issue(2'b10, 5'd3,  16'h0100, 1'b0, 1'b1);

    start = 1'b1; mode = 2'b11; rd_in = 5'd4; z_in = 16'h0100;
    @(negedge clk);
    start = 1'b0;
    check("reserved_mode", busy, 1'b0);
    @(negedge clk);

    issue(2'b01, 5'd20, 16'h0201, 1'b1, 1'b0);
    check("abort_idle", busy, 1'b0);
    issue(2'b01, 5'd21, 16'h0201, 1'b0, 1'b0);

    for (int i = 0; i < 6; i++) begin
      logic [15:0] zr;
      zr = 16'($urandom);
      issue(2'($urandom_range(0, 2)), 5'($urandom_range(0, 31)), zr, 1'b0, 1'b0);
    end

    repeat (3) @(negedge clk);
    check("sb_empty", sb_q.size(), 0);
    check("done_count", n_done, n_pushed);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
